// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR period checker.
// The optional ones-count accumulator is enabled with LFSR_CHK_ONES_COUNT_EN.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    // Period/count registers carry one extra bit so a full 2**w count never wraps.
    function automatic int period_w(input int w);
        return w + 1;
    endfunction

    function automatic int max_period(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/lfsr_period_checker.sv
// Measures the period of an LFSR sequence from a captured reference state and flags
// maximal-length, all-zero lock-up and timeout outcomes. Macro: LFSR_CHK_ONES_COUNT_EN.
module lfsr_period_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LIMIT = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [WIDTH-1:0] lfsr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             maximal,
    output logic             lockup,
    output logic             timeout,
    output logic [WIDTH:0]   ones_count,
    output state_t           state_dbg
);

    localparam int                PW      = period_w(WIDTH);
    localparam logic [PW-1:0]     MAX_V   = PW'(max_period(WIDTH));
    localparam logic [PW-1:0]     LIMIT_V = PW'(LIMIT);

    state_t           state;
    logic [PW-1:0]    cnt;
    logic [PW-1:0]    n;
    logic [WIDTH-1:0] ref_q;
    logic             ref_hit;
    logic             zero_hit;

    assign n         = cnt + PW'(1);
    assign ref_hit   = (lfsr_in == ref_q);
    assign zero_hit  = (lfsr_in == '0);
    assign state_dbg = state;

    // done defaults low every cycle so it is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            period  <= '0;
            maximal <= 1'b0;
            lockup  <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            ref_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        period  <= '0;
                        maximal <= 1'b0;
                        lockup  <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                ARM: begin
                    if (enable) begin
                        ref_q <= lfsr_in;
                        cnt   <= '0;
                        if (zero_hit) begin
                            lockup <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // Return to reference wins over lock-up and timeout on the same sample.
                    if (enable) begin
                        if (ref_hit) begin
                            period  <= n;
                            maximal <= (n == MAX_V);
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (zero_hit) begin
                            lockup <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else if (n == LIMIT_V) begin
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            cnt <= n;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LFSR_CHK_ONES_COUNT_EN
    logic [PW-1:0] ones_q;

    // Counts bit 0 over one full period: the reference plus every non-closing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ones_q <= '0;
        end else if (state == IDLE && start) begin
            ones_q <= '0;
        end else if (enable && state == ARM) begin
            ones_q <= PW'(lfsr_in[0]);
        end else if (enable && state == COUNT && !ref_hit) begin
            ones_q <= ones_q + PW'(lfsr_in[0]);
        end
    end

    assign ones_count = ones_q;
`else
    assign ones_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker (WIDTH=3, LIMIT=8).
// Expected ones_count values follow LFSR_CHK_ONES_COUNT_EN.
module tb_lfsr_period_checker;
    import lfsr_pkg::*;

    localparam int WIDTH = 3;
    localparam int LIMIT = 8;

`ifdef LFSR_CHK_ONES_COUNT_EN
    localparam bit ONES_EN = 1'b1;
`else
    localparam bit ONES_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             enable;
    logic [WIDTH-1:0] lfsr_in;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   period;
    logic             maximal;
    logic             lockup;
    logic             timeout;
    logic [WIDTH:0]   ones_count;
    state_t           state_dbg;

    int tests  = 0;
    int failed = 0;

    lfsr_period_checker #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .lfsr_in    (lfsr_in),
        .busy       (busy),
        .done       (done),
        .period     (period),
        .maximal    (maximal),
        .lockup     (lockup),
        .timeout    (timeout),
        .ones_count (ones_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] v, input int holes);
        for (int h = 0; h < holes; h++) begin
            enable = 1'b0;
            tick();
        end
        enable  = 1'b1;
        lfsr_in = v;
        tick();
        enable  = 1'b0;
        lfsr_in = $urandom_range(0, 7);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] ones_exp(input int v);
        return ONES_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic chk_result(input string tag, input int p, input bit m, input bit l,
                              input bit t, input int ones);
        chk({tag, "_done"},    32'(done),       32'd1);
        chk({tag, "_busy"},    32'(busy),       32'd0);
        chk({tag, "_period"},  32'(period),     32'(p));
        chk({tag, "_maximal"}, 32'(maximal),    32'(m));
        chk({tag, "_lockup"},  32'(lockup),     32'(l));
        chk({tag, "_timeout"}, 32'(timeout),    32'(t));
        chk({tag, "_ones"},    32'(ones_count), ones_exp(ones));
    endtask

    initial begin
        logic [WIDTH-1:0] seq1 [8] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};

        reset   = 1'b1;
        start   = 1'b0;
        enable  = 1'b0;
        lfsr_in = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_done",    32'(done),       32'd0);
        chk("rst_period",  32'(period),     32'd0);
        chk("rst_maximal", 32'(maximal),    32'd0);
        chk("rst_lockup",  32'(lockup),     32'd0);
        chk("rst_timeout", 32'(timeout),    32'd0);
        chk("rst_ones",    32'(ones_count), 32'd0);
        chk("rst_state",   32'(state_dbg),  32'(IDLE));

        // 1: maximal sequence; a sample on the start cycle must be ignored.
        start   = 1'b1;
        enable  = 1'b1;
        lfsr_in = 3'd7;
        tick();
        start  = 1'b0;
        enable = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) send(seq1[i], 0);
        chk("t1_nodone", 32'(done), 32'd0);
        send(seq1[7], 0);
        chk_result("t1", 7, 1'b1, 1'b0, 1'b0, 4);
        tick();
        chk("t1_pulse",  32'(done),   32'd0);
        chk("t1_hold",   32'(period), 32'd7);

        // 2: short period of 2.
        pulse_start();
        send(3'd1, 0);
        send(3'd3, 0);
        send(3'd1, 0);
        chk_result("t2", 2, 1'b0, 1'b0, 1'b0, 2);

        // 3a: start accepted in the done cycle, then lock-up from COUNT.
        pulse_start();
        chk("t3_busy",    32'(busy),   32'd1);
        chk("t3_clr",     32'(period), 32'd0);
        send(3'd5, 0);
        send(3'd0, 0);
        chk_result("t3a", 0, 1'b0, 1'b1, 1'b0, 1);
        tick();

        // 3b: lock-up on the reference sample itself.
        pulse_start();
        send(3'd0, 0);
        chk_result("t3b", 0, 1'b0, 1'b1, 1'b0, 0);
        tick();

        // 4: never returns to the reference; timeout on the 8th sample after it.
        pulse_start();
        send(3'd1, 0);
        for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 3'd2 : 3'd3, 0);
        chk("t4_nodone",  32'(done),    32'd0);
        chk("t4_notmo",   32'(timeout), 32'd0);
        send(3'd3, 0);
        chk_result("t4", 0, 1'b0, 1'b0, 1'b1, 5);
        tick();

        // 5: holes between samples and a stray start mid-COUNT.
        pulse_start();
        for (int i = 0; i < 4; i++) send(seq1[i], 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_state", 32'(state_dbg), 32'(COUNT));
        for (int i = 4; i < 8; i++) send(seq1[i], 3);
        chk_result("t5", 7, 1'b1, 1'b0, 1'b0, 4);
        tick();

        // 6: reset mid-COUNT aborts silently; a fresh measurement then works.
        pulse_start();
        send(3'd1, 0);
        send(3'd2, 0);
        send(3'd5, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy",   32'(busy),      32'd0);
        chk("t6_done",   32'(done),      32'd0);
        chk("t6_period", 32'(period),    32'd0);
        chk("t6_state",  32'(state_dbg), 32'(IDLE));
        send(3'd1, 0);
        chk("t6_nodone", 32'(done), 32'd0);
        pulse_start();
        send(3'd1, 0);
        send(3'd3, 0);
        send(3'd1, 0);
        chk_result("t6", 2, 1'b0, 1'b0, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
